// File: rtl/ofm_stream_reader.sv
// Drains the OFM DPRAM after a start pulse and emits it as a valid/ready word stream.
// A 2-entry prefetch FIFO with read credits hides the 1-cycle DPRAM latency.
//
// state  | meaning
// IDLE   | waiting for start
// STREAM | issuing DPRAM reads, one per free FIFO credit
// DRAIN  | all reads issued, waiting for the m_last handshake
// FIN    | one-cycle done pulse
module ofm_stream_reader #(
   parameter int DATA_WIDTH  = 8,
   parameter int INOUT_WIDTH = 128,
   parameter int OFM_SIZE    = 208,
   parameter int NO_FILTER   = 16,
   parameter int ADDR_WIDTH  = 17
) (
   input  logic                                        clk,
   input  logic                                        rst_n,
   input  logic                                        start,
   output logic                                        ofm_rd_en,
   output logic [ADDR_WIDTH-1:0]                       ofm_rd_addr,
   input  logic [INOUT_WIDTH-1:0]                      ofm_rd_data,
   output logic                                        m_valid,
   input  logic                                        m_ready,
   output logic [INOUT_WIDTH-1:0]                      m_data,
   output logic [INOUT_WIDTH/(2*DATA_WIDTH)-1:0]       m_keep,
   output logic                                        m_last,
   output logic                                        busy,
   output logic                                        done
);

   localparam int ELEMS       = INOUT_WIDTH / (2 * DATA_WIDTH);
   localparam int EW          = 2 * DATA_WIDTH;
   localparam int TOTAL_ELEMS = OFM_SIZE * OFM_SIZE * NO_FILTER;
   localparam int NO_WORDS    = (TOTAL_ELEMS + ELEMS - 1) / ELEMS;
   localparam int LAST_LANES  = (TOTAL_ELEMS % ELEMS == 0) ? ELEMS : TOTAL_ELEMS % ELEMS;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NO_WORDS - 1);
   localparam logic [ELEMS-1:0]      KEEP_ALL  = '1;
   localparam logic [ELEMS-1:0]      LAST_KEEP = KEEP_ALL >> (ELEMS - LAST_LANES);

   function automatic logic [INOUT_WIDTH-1:0] keep_to_mask(input logic [ELEMS-1:0] keep);
      logic [INOUT_WIDTH-1:0] m;
      m = '0;
      for (int k = 0; k < ELEMS; k++) m[k*EW +: EW] = {EW{keep[k]}};
      return m;
   endfunction

   localparam logic [INOUT_WIDTH-1:0] LAST_MASK = keep_to_mask(LAST_KEEP);

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FIN} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    inflight_q, inflight_d;
   logic                    inflight_last_q, inflight_last_d;
   logic [1:0]              count_q, count_d;
   logic                    rd_ptr_q, wr_ptr_q;
   logic [INOUT_WIDTH-1:0]  mem_q [2];
   logic [1:0]              last_q;

   logic                    valid;
   logic                    pop;
   logic                    push;
   logic                    issue;
   logic [2:0]              occ;

   assign valid = (count_q != 2'd0);
   assign pop   = valid & m_ready;
   assign push  = inflight_q;
   assign occ   = {1'b0, count_q} + {2'b00, inflight_q};

   // A credit freed by this cycle's pop may be reused immediately for full throughput.
   assign issue = (state_q == STREAM) && ((occ - {2'b00, pop}) < 3'd2);

   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      inflight_d      = issue;
      inflight_last_d = issue && (addr_q == LAST_ADDR);
      count_d         = count_q + {1'b0, push} - {1'b0, pop};
      busy            = 1'b0;
      done            = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = STREAM;
               addr_d  = '0;
            end
         end
         STREAM: begin
            busy = 1'b1;
            if (issue) begin
               addr_d = addr_q + ADDR_WIDTH'(1);
               if (addr_q == LAST_ADDR) state_d = DRAIN;
            end
         end
         DRAIN: begin
            busy = 1'b1;
            if (pop && last_q[rd_ptr_q]) state_d = FIN;
         end
         FIN: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         addr_q          <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         count_q         <= 2'd0;
         rd_ptr_q        <= 1'b0;
         wr_ptr_q        <= 1'b0;
         last_q          <= 2'b00;
         mem_q[0]        <= '0;
         mem_q[1]        <= '0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         count_q         <= count_d;
         if (push) begin
            mem_q[wr_ptr_q]  <= ofm_rd_data & (inflight_last_q ? LAST_MASK : '1);
            last_q[wr_ptr_q] <= inflight_last_q;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
      end
   end

   assign ofm_rd_en   = issue;
   assign ofm_rd_addr = issue ? addr_q : '0;
   assign m_valid     = valid;
   assign m_data      = valid ? mem_q[rd_ptr_q] : '0;
   assign m_last      = valid & last_q[rd_ptr_q];
   assign m_keep      = !valid ? '0 : (last_q[rd_ptr_q] ? LAST_KEEP : KEEP_ALL);

endmodule

// File: tb/tb_ofm_stream_reader.sv
// Bench for ofm_stream_reader: a small directed instance (20 elements, 3 words) and a
// larger instance (576 elements, 72 words) driven with random back-pressure.
module tb_ofm_stream_reader;

   localparam int IW = 128;
   localparam int EL = 8;
   localparam int AW = 17;
   localparam int S_TOT = 20;
   localparam int S_WORDS = 3;
   localparam int R_TOT = 576;
   localparam int R_WORDS = 72;

   typedef struct packed {
      logic [IW-1:0] data;
      logic [EL-1:0] keep;
      logic          last;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail = 0;

   // small instance
   logic          s_start = 1'b0, s_ready = 1'b0;
   logic          s_rd_en, s_valid, s_last, s_busy, s_done;
   logic [AW-1:0] s_addr;
   logic [IW-1:0] s_rd_data = '0, s_data;
   logic [EL-1:0] s_keep;
   // random instance
   logic          r_start = 1'b0, r_ready = 1'b0;
   logic          r_rd_en, r_valid, r_last, r_busy, r_done;
   logic [AW-1:0] r_addr;
   logic [IW-1:0] r_rd_data = '0, r_data;
   logic [EL-1:0] r_keep;

   ofm_stream_reader #(.DATA_WIDTH(8), .INOUT_WIDTH(IW), .OFM_SIZE(2), .NO_FILTER(5), .ADDR_WIDTH(AW)) u_s (
      .clk(clk), .rst_n(rst_n), .start(s_start), .ofm_rd_en(s_rd_en), .ofm_rd_addr(s_addr),
      .ofm_rd_data(s_rd_data), .m_valid(s_valid), .m_ready(s_ready), .m_data(s_data),
      .m_keep(s_keep), .m_last(s_last), .busy(s_busy), .done(s_done));

   ofm_stream_reader #(.DATA_WIDTH(8), .INOUT_WIDTH(IW), .OFM_SIZE(6), .NO_FILTER(16), .ADDR_WIDTH(AW)) u_r (
      .clk(clk), .rst_n(rst_n), .start(r_start), .ofm_rd_en(r_rd_en), .ofm_rd_addr(r_addr),
      .ofm_rd_data(r_rd_data), .m_valid(r_valid), .m_ready(r_ready), .m_data(r_data),
      .m_keep(r_keep), .m_last(r_last), .busy(r_busy), .done(r_done));

   function automatic logic [15:0] elem_val(input int idx, input bit alt);
      return alt ? 16'(idx * 37 + 5) : 16'(idx);
   endfunction

   function automatic logic [IW-1:0] ram_word(input int w, input bit alt);
      logic [IW-1:0] d;
      for (int k = 0; k < EL; k++) d[16*k +: 16] = elem_val(EL * w + k, alt);
      return d;
   endfunction

   function automatic beat_t exp_beat(input int w, input int words, input int total, input bit alt);
      beat_t b;
      b.data = '0;
      for (int k = 0; k < EL; k++) begin
         b.keep[k] = (EL * w + k) < total;
         if (b.keep[k]) b.data[16*k +: 16] = elem_val(EL * w + k, alt);
      end
      b.last = (w == words - 1);
      return b;
   endfunction

   always @(posedge clk) if (s_rd_en) s_rd_data <= ram_word(int'(s_addr), 1'b0);
   always @(posedge clk) if (r_rd_en) r_rd_data <= ram_word(int'(r_addr), 1'b1);

   task automatic chk(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   beat_t s_q[$], r_q[$];
   int    s_beat_cyc[$];
   int    s_beats, s_lasts, s_rd_cnt, s_done_cnt, s_done_cyc, s_maxcnt = 0;
   int    r_beats, r_lasts, r_done_cnt, r_maxcnt = 0;
   int    c0;

   always @(negedge clk) begin
      beat_t e;
      if (s_valid && s_ready) begin
         chk("s_beat_expected", (s_q.size() != 0), 1);
         if (s_q.size() != 0) begin
            e = s_q.pop_front();
            chk("s_data", s_data, e.data);
            chk("s_keep", s_keep, e.keep);
            chk("s_last", s_last, e.last);
         end
         s_beats++;
         s_beat_cyc.push_back(cyc);
         if (s_last) s_lasts++;
      end
      if (s_rd_en) s_rd_cnt++;
      if (s_done) begin
         s_done_cnt++;
         s_done_cyc = cyc;
      end
      if (int'(u_s.count_q) > s_maxcnt) s_maxcnt = int'(u_s.count_q);
      if (r_valid && r_ready) begin
         chk("r_beat_expected", (r_q.size() != 0), 1);
         if (r_q.size() != 0) begin
            e = r_q.pop_front();
            chk("r_data", r_data, e.data);
            chk("r_keep", r_keep, e.keep);
            chk("r_last", r_last, e.last);
         end
         r_beats++;
         if (r_last) r_lasts++;
      end
      if (r_done) r_done_cnt++;
      if (int'(u_r.count_q) > r_maxcnt) r_maxcnt = int'(u_r.count_q);
   end

   function automatic int beat_rel(input int i);
      return (s_beat_cyc.size() > i) ? s_beat_cyc[i] - c0 : -1;
   endfunction

   // Called just after a rising edge: start is high for that cycle (cycle 0).
   task automatic s_kick();
      s_beats = 0; s_lasts = 0; s_rd_cnt = 0; s_done_cnt = 0; s_done_cyc = -1;
      s_beat_cyc.delete();
      for (int w = 0; w < S_WORDS; w++) s_q.push_back(exp_beat(w, S_WORDS, S_TOT, 1'b0));
      s_start = 1'b1;
      c0 = cyc;
      @(posedge clk); #1 s_start = 1'b0;
   endtask

   task automatic s_wait_done(input string tag);
      for (int i = 0; i < 200 && s_done_cnt == 0; i++) begin
         @(negedge clk); #1;
      end
      chk({tag, "_done_seen"}, (s_done_cnt != 0), 1);
      repeat (4) @(negedge clk);
      #1;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_rd_en"}, s_rd_en, 0);
      chk({tag, "_addr"},  s_addr, 0);
      chk({tag, "_valid"}, s_valid, 0);
      chk({tag, "_data"},  s_data, 0);
      chk({tag, "_keep"},  s_keep, 0);
      chk({tag, "_last"},  s_last, 0);
      chk({tag, "_busy"},  s_busy, 0);
      chk({tag, "_done"},  s_done, 0);
   endtask

   initial begin
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk_idle_outputs("rst");
      @(posedge clk); #1 rst_n = 1'b1;

      // latency and full-throughput drain
      @(posedge clk); #1 s_ready = 1'b1;
      s_kick();
      @(negedge clk);
      chk("lat_rd_en_c1", s_rd_en, 1); chk("lat_addr_c1", s_addr, 0); chk("lat_valid_c1", s_valid, 0);
      @(negedge clk);
      chk("lat_rd_en_c2", s_rd_en, 1); chk("lat_addr_c2", s_addr, 1); chk("lat_busy_c2", s_busy, 1);
      @(negedge clk);
      chk("lat_valid_c3", s_valid, 1); chk("lat_data_c3", s_data, ram_word(0, 1'b0));
      s_wait_done("lat");
      chk("lat_beats", s_beats, 3);
      chk("lat_beat0_cyc", beat_rel(0), 3);
      chk("lat_beat2_cyc", beat_rel(2), 5);
      chk("lat_done_cyc", s_done_cyc - c0, 6);
      chk("lat_done_cnt", s_done_cnt, 1);
      chk("lat_lasts", s_lasts, 1);
      chk("lat_q_empty", s_q.size(), 0);

      // back-pressure: ten stalled cycles after the first valid
      @(posedge clk); #1 s_ready = 1'b0;
      s_kick();
      for (int i = 0; i < 20 && !s_valid; i++) @(negedge clk);
      chk("bp_valid_seen", s_valid, 1);
      chk("bp_valid_cyc", cyc - c0, 3);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_data_frozen", s_data, ram_word(0, 1'b0));
      end
      chk("bp_rd_cnt", s_rd_cnt, 2);
      chk("bp_no_beats", s_beats, 0);
      @(posedge clk); #1 s_ready = 1'b1;
      s_wait_done("bp");
      chk("bp_beats", s_beats, 3);
      chk("bp_no_gaps", beat_rel(2) - beat_rel(0), 2);
      chk("bp_done_after_last", s_done_cyc - c0, beat_rel(2) + 1);
      chk("bp_done_cnt", s_done_cnt, 1);
      chk("bp_q_empty", s_q.size(), 0);

      // start pulses while busy are ignored
      s_kick();
      s_start = 1'b1; @(posedge clk); #1 s_start = 1'b0;
      @(posedge clk); #1 s_start = 1'b1; @(posedge clk); #1 s_start = 1'b0;
      s_wait_done("busy_start");
      repeat (6) @(negedge clk);
      chk("busy_start_beats", s_beats, 3);
      chk("busy_start_done_cnt", s_done_cnt, 1);
      chk("busy_start_rd_cnt", s_rd_cnt, 3);
      chk("busy_start_q_empty", s_q.size(), 0);

      // reset after the first beat, then a clean replay
      @(posedge clk); #1 s_ready = 1'b0;
      s_kick();
      for (int i = 0; i < 20 && !s_valid; i++) @(negedge clk);
      @(posedge clk); #1 s_ready = 1'b1;
      @(posedge clk); #1 s_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_beats", s_beats, 1);
      chk_idle_outputs("mid_rst");
      s_q.delete();
      r_q.delete();
      @(posedge clk); #1 rst_n = 1'b1; s_ready = 1'b1;
      @(posedge clk); #1;
      s_kick();
      @(negedge clk);
      chk("replay_addr_c1", s_addr, 0); chk("replay_rd_en_c1", s_rd_en, 1);
      s_wait_done("replay");
      chk("replay_beats", s_beats, 3);
      chk("replay_done_cnt", s_done_cnt, 1);
      chk("replay_q_empty", s_q.size(), 0);
      chk("s_fifo_max", (s_maxcnt <= 2), 1);

      // random back-pressure on the larger instance
      r_beats = 0; r_lasts = 0; r_done_cnt = 0;
      for (int w = 0; w < R_WORDS; w++) r_q.push_back(exp_beat(w, R_WORDS, R_TOT, 1'b1));
      @(posedge clk); #1 r_start = 1'b1;
      @(posedge clk); #1 r_start = 1'b0;
      @(negedge clk);
      chk("r_busy", r_busy, 1);
      for (int i = 0; i < 3000 && r_done_cnt == 0; i++) begin
         @(posedge clk); #1 r_ready = 1'($urandom_range(0, 1));
      end
      repeat (4) @(negedge clk);
      chk("r_done_seen", r_done_cnt, 1);
      chk("r_beats", r_beats, R_WORDS);
      chk("r_lasts", r_lasts, 1);
      chk("r_q_empty", r_q.size(), 0);
      chk("r_fifo_max", (r_maxcnt <= 2), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
